// File: rtl/i2c_target_rx.sv
// Write-only I2C target: filtered SCL/SDA, START/STOP detection, address match,
// byte reception handed off over valid/ready, open-drain ACK generation.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h2A,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3,
  parameter int         SDA_OE_BIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       read_channel,
  output logic       write_channel,
  output logic [7:0] direction,
  output logic       seen_start,
  output logic       seen_repeated_start,
  output logic       seen_stop,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addr_match,
  output logic       overrun
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_S, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  logic [1:0] raw_in;
  logic [1:0] filt;

  assign raw_in = {read_channel, sck};

  // Per line: synchroniser chain, then a stability counter that only lets the
  // filtered value follow once the synced value has differed for FILTER_LEN cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   filt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '1;
          cnt_reg  <= '0;
          filt_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
          if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
            filt_reg <= sync_reg[SYNC_STAGES-1];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic fs, fd;
  logic fs_prev_reg, fd_prev_reg;
  logic fs_rise, fs_fall, start_evt, stop_evt;

  assign fs        = filt[0];
  assign fd        = filt[1];
  assign fs_rise   = fs & ~fs_prev_reg;
  assign fs_fall   = ~fs & fs_prev_reg;
  assign start_evt = fs & fs_prev_reg & fd_prev_reg & ~fd;
  assign stop_evt  = fs & fs_prev_reg & ~fd_prev_reg & fd;

  state_t     state_reg;
  logic [7:0] shift_reg;
  logic [3:0] bit_cnt_reg;
  logic       ack_reg;

  // The pad is only ever driven low; releasing means turning the enable off.
  assign write_channel = ~ack_reg;
  assign direction     = 8'(ack_reg) << SDA_OE_BIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_prev_reg         <= 1'b1;
      fd_prev_reg         <= 1'b1;
      state_reg           <= IDLE;
      shift_reg           <= '0;
      bit_cnt_reg         <= '0;
      ack_reg             <= 1'b0;
      seen_start          <= 1'b0;
      seen_repeated_start <= 1'b0;
      seen_stop           <= 1'b0;
      rx_data             <= '0;
      rx_valid            <= 1'b0;
      addr_match          <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      fs_prev_reg         <= fs;
      fd_prev_reg         <= fd;
      seen_start          <= 1'b0;
      seen_repeated_start <= 1'b0;
      seen_stop           <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      // Bus conditions take priority over any SCL edge seen in the same cycle.
      if (stop_evt) begin
        state_reg  <= IDLE;
        seen_stop  <= 1'b1;
        ack_reg    <= 1'b0;
        addr_match <= 1'b0;
      end else if (start_evt) begin
        state_reg   <= ADDR_S;
        bit_cnt_reg <= '0;
        ack_reg     <= 1'b0;
        addr_match  <= 1'b0;
        if (state_reg == IDLE) seen_start <= 1'b1;
        else                   seen_repeated_start <= 1'b1;
      end else begin
        case (state_reg)
          ADDR_S: begin
            if (fs_rise) begin
              shift_reg   <= {shift_reg[6:0], fd};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else if (fs_fall && bit_cnt_reg == 4'd8) begin
              if (shift_reg[7:1] == ADDR && !shift_reg[0]) begin
                ack_reg   <= 1'b1;
                state_reg <= ADDR_ACK;
              end else begin
                state_reg <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (fs_fall) begin
              ack_reg     <= 1'b0;
              addr_match  <= 1'b1;
              bit_cnt_reg <= '0;
              state_reg   <= DATA;
            end
          end
          DATA: begin
            if (fs_rise) begin
              shift_reg   <= {shift_reg[6:0], fd};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else if (fs_fall && bit_cnt_reg == 4'd8) begin
              if (!rx_valid || rx_ready) begin
                rx_data   <= shift_reg;
                rx_valid  <= 1'b1;
                ack_reg   <= 1'b1;
                state_reg <= DATA_ACK;
              end else begin
                overrun   <= 1'b1;
                state_reg <= IGNORE;
              end
            end
          end
          DATA_ACK: begin
            if (fs_fall) begin
              ack_reg     <= 1'b0;
              bit_cnt_reg <= '0;
              state_reg   <= DATA;
            end
          end
          IDLE, IGNORE: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bit-banged I2C master on a wired-AND SDA
// line, a byte-logging consumer and per-scenario inline checks.
module tb_i2c_target_rx;

  localparam int HP = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       rx_ready;
  logic       bus_sda;
  logic       write_channel;
  logic [7:0] direction;
  logic       seen_start, seen_repeated_start, seen_stop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  int n_start = 0, n_rstart = 0, n_stop = 0;
  int dir_cycles = 0, dir_bad = 0, rx_count = 0;
  logic [7:0] rx_log [0:63];

  always #5 clk = ~clk;

  assign bus_sda = sda_m & ~(direction[3] & ~write_channel);

  i2c_target_rx dut (
    .clk                 (clk),
    .reset               (reset),
    .sck                 (scl_m),
    .read_channel        (bus_sda),
    .write_channel       (write_channel),
    .direction           (direction),
    .seen_start          (seen_start),
    .seen_repeated_start (seen_repeated_start),
    .seen_stop           (seen_stop),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .addr_match          (addr_match),
    .overrun             (overrun)
  );

  always @(negedge clk) begin
    if (seen_start)          n_start  <= n_start + 1;
    if (seen_repeated_start) n_rstart <= n_rstart + 1;
    if (seen_stop)           n_stop   <= n_stop + 1;
    if (direction != 8'h00)  dir_cycles <= dir_cycles + 1;
    if ((direction & 8'hF7) != 8'h00 || (direction[3] == write_channel))
      dir_bad <= dir_bad + 1;
    if (rx_valid && rx_ready) begin
      rx_log[rx_count % 64] <= rx_data;
      rx_count <= rx_count + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(HP);
    scl_m = 1'b1; tick(HP);
    sda_m = 1'b0; tick(HP);
    scl_m = 1'b0; tick(HP);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(HP);
    scl_m = 1'b1; tick(HP);
    sda_m = 1'b1; tick(HP);
  endtask

  task automatic bus_bit(input logic b, input logic glitch);
    sda_m = b;
    tick(HP / 2);
    if (glitch) begin
      scl_m = 1'b1; tick(2);
      scl_m = 1'b0;
    end
    tick(HP / 2);
    scl_m = 1'b1; tick(HP);
    scl_m = 1'b0; tick(HP);
  endtask

  task automatic bus_byte(input logic [7:0] b, input int glitch_bit,
                          output logic ack_n, output logic [7:0] dir_seen);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], (7 - i) == glitch_bit);
    sda_m = 1'b1; tick(HP);
    scl_m = 1'b1; tick(HP / 2);
    ack_n    = bus_sda;
    dir_seen = direction;
    tick(HP / 2);
    scl_m = 1'b0; tick(HP);
    $display("  txn: byte 0x%02h ack_n=%0b dir=0x%02h", b, ack_n, dir_seen);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b0;
    tick(5);
    reset = 1'b0;
    tick(20);
    n_vec++; if (write_channel !== 1'b1) begin n_err++; $display("FAIL reset_write_channel got %0b exp 1", write_channel); end
    n_vec++; if (direction !== 8'h00) begin n_err++; $display("FAIL reset_direction got %02h exp 00", direction); end
    n_vec++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx got v=%0b d=%02h exp v=0 d=00", rx_valid, rx_data); end
    n_vec++; if ({overrun, addr_match} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {overrun, addr_match}); end
    n_vec++; if ((n_start + n_rstart + n_stop) !== 0) begin n_err++; $display("FAIL reset_pulses got %0d exp 0", n_start + n_rstart + n_stop); end
    $display("  txn: reset done");
  endtask

  task automatic test_basic();
    logic a; logic [7:0] d;
    int s0, p0, q0, r0;
    s0 = n_start; p0 = n_stop; q0 = n_rstart; r0 = rx_count;
    rx_ready = 1'b1;
    bus_start();
    bus_byte(8'h54, -1, a, d);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL basic_addr_ack got %0b exp 0", a); end
    n_vec++; if (d !== 8'h08) begin n_err++; $display("FAIL basic_ack_direction got %02h exp 08", d); end
    n_vec++; if (addr_match !== 1'b1) begin n_err++; $display("FAIL basic_addr_match got %0b exp 1", addr_match); end
    bus_byte(8'hA5, -1, a, d);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL basic_data1_ack got %0b exp 0", a); end
    bus_byte(8'h3C, -1, a, d);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL basic_data2_ack got %0b exp 0", a); end
    bus_stop();
    tick(20);
    n_vec++; if (n_start - s0 !== 1 || n_stop - p0 !== 1 || n_rstart - q0 !== 0) begin n_err++; $display("FAIL basic_pulses got s=%0d p=%0d r=%0d exp 1 1 0", n_start - s0, n_stop - p0, n_rstart - q0); end
    n_vec++; if (rx_count - r0 !== 2) begin n_err++; $display("FAIL basic_rx_count got %0d exp 2", rx_count - r0); end
    n_vec++; if (rx_log[r0 % 64] !== 8'hA5) begin n_err++; $display("FAIL basic_byte0 got %02h exp A5", rx_log[r0 % 64]); end
    n_vec++; if (rx_log[(r0 + 1) % 64] !== 8'h3C) begin n_err++; $display("FAIL basic_byte1 got %02h exp 3C", rx_log[(r0 + 1) % 64]); end
    n_vec++; if (addr_match !== 1'b0) begin n_err++; $display("FAIL basic_match_after_stop got %0b exp 0", addr_match); end
  endtask

  task automatic test_no_match();
    logic a; logic [7:0] d;
    int d0, r0;
    d0 = dir_cycles; r0 = rx_count;
    rx_ready = 1'b1;
    bus_start();
    bus_byte(8'h55, -1, a, d);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL nomatch_read_ack got %0b exp 1", a); end
    bus_byte(8'hA5, -1, a, d);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL nomatch_read_data_ack got %0b exp 1", a); end
    bus_stop();
    bus_start();
    bus_byte(8'h56, -1, a, d);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL nomatch_addr_ack got %0b exp 1", a); end
    bus_byte(8'h3C, -1, a, d);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL nomatch_addr_data_ack got %0b exp 1", a); end
    bus_stop();
    tick(20);
    n_vec++; if (dir_cycles - d0 !== 0) begin n_err++; $display("FAIL nomatch_direction got %0d cycles exp 0", dir_cycles - d0); end
    n_vec++; if (rx_count - r0 !== 0 || rx_valid !== 1'b0) begin n_err++; $display("FAIL nomatch_rx got %0d v=%0b exp 0 v=0", rx_count - r0, rx_valid); end
    n_vec++; if (addr_match !== 1'b0) begin n_err++; $display("FAIL nomatch_addr_match got %0b exp 0", addr_match); end
  endtask

  task automatic test_overrun();
    logic a; logic [7:0] d;
    int r0;
    r0 = rx_count;
    rx_ready = 1'b0;
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_initial got %0b exp 0", overrun); end
    bus_start();
    bus_byte(8'h54, -1, a, d);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL overrun_addr_ack got %0b exp 0", a); end
    bus_byte(8'h11, -1, a, d);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL overrun_first_ack got %0b exp 0", a); end
    bus_byte(8'h22, -1, a, d);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL overrun_second_nack got %0b exp 1", a); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag got %0b exp 1", overrun); end
    n_vec++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin n_err++; $display("FAIL overrun_held got v=%0b d=%02h exp v=1 d=11", rx_valid, rx_data); end
    bus_stop();
    tick(20);
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL overrun_valid_after_stop got %0b exp 1", rx_valid); end
    rx_ready = 1'b1;
    tick(3);
    n_vec++; if (rx_count - r0 !== 1 || rx_log[r0 % 64] !== 8'h11) begin n_err++; $display("FAIL overrun_drain got n=%0d d=%02h exp n=1 d=11", rx_count - r0, rx_log[r0 % 64]); end
    n_vec++; if (rx_valid !== 1'b0 || overrun !== 1'b1) begin n_err++; $display("FAIL overrun_after_drain got v=%0b o=%0b exp v=0 o=1", rx_valid, overrun); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2, a3; logic [7:0] d;
    int s0, p0, q0, r0;
    s0 = n_start; p0 = n_stop; q0 = n_rstart; r0 = rx_count;
    rx_ready = 1'b1;
    bus_start();
    bus_byte(8'h54, -1, a0, d);
    bus_byte(8'h77, -1, a1, d);
    bus_start();
    n_vec++; if (addr_match !== 1'b0) begin n_err++; $display("FAIL rstart_clears_match got %0b exp 0", addr_match); end
    bus_byte(8'h54, -1, a2, d);
    bus_byte(8'h88, -1, a3, d);
    bus_stop();
    tick(20);
    n_vec++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL rstart_acks got %b exp 0000", {a0, a1, a2, a3}); end
    n_vec++; if (n_start - s0 !== 1 || n_rstart - q0 !== 1 || n_stop - p0 !== 1) begin n_err++; $display("FAIL rstart_pulses got s=%0d r=%0d p=%0d exp 1 1 1", n_start - s0, n_rstart - q0, n_stop - p0); end
    n_vec++; if (rx_count - r0 !== 2 || rx_log[r0 % 64] !== 8'h77 || rx_log[(r0 + 1) % 64] !== 8'h88) begin n_err++; $display("FAIL rstart_bytes got n=%0d %02h %02h exp 2 77 88", rx_count - r0, rx_log[r0 % 64], rx_log[(r0 + 1) % 64]); end
  endtask

  task automatic test_glitch();
    logic a0, a1, a2; logic [7:0] d;
    int r0;
    r0 = rx_count;
    rx_ready = 1'b1;
    bus_start();
    bus_byte(8'h54, 5, a0, d);
    bus_byte(8'h96, 3, a1, d);
    bus_byte(8'h5A, 6, a2, d);
    bus_stop();
    tick(20);
    n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL glitch_acks got %b exp 000", {a0, a1, a2}); end
    n_vec++; if (rx_count - r0 !== 2 || rx_log[r0 % 64] !== 8'h96 || rx_log[(r0 + 1) % 64] !== 8'h5A) begin n_err++; $display("FAIL glitch_bytes got n=%0d %02h %02h exp 2 96 5A", rx_count - r0, rx_log[r0 % 64], rx_log[(r0 + 1) % 64]); end
  endtask

  task automatic test_reset_mid_ack();
    logic a0, a1; logic [7:0] d;
    int s0, r0;
    rx_ready = 1'b1;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(((8'h54 >> i) & 8'h01) != 8'h00, 1'b0);
    sda_m = 1'b1; tick(HP);
    n_vec++; if (direction !== 8'h08 || write_channel !== 1'b0) begin n_err++; $display("FAIL midack_driving got dir=%02h wc=%0b exp 08 0", direction, write_channel); end
    reset = 1'b1;
    tick(1);
    n_vec++; if (direction !== 8'h00 || write_channel !== 1'b1) begin n_err++; $display("FAIL midack_released got dir=%02h wc=%0b exp 00 1", direction, write_channel); end
    n_vec++; if ({seen_start, seen_repeated_start, seen_stop, addr_match, overrun, rx_valid} !== 6'b0) begin n_err++; $display("FAIL midack_cleared got %b exp 000000", {seen_start, seen_repeated_start, seen_stop, addr_match, overrun, rx_valid}); end
    reset = 1'b0;
    $display("  txn: reset during ACK");
    scl_m = 1'b1; tick(HP);
    scl_m = 1'b0; tick(HP);
    bus_stop();
    tick(20);
    s0 = n_start; r0 = rx_count;
    bus_start();
    bus_byte(8'h54, -1, a0, d);
    bus_byte(8'hC3, -1, a1, d);
    bus_stop();
    tick(20);
    n_vec++; if ({a0, a1} !== 2'b00 || n_start - s0 !== 1) begin n_err++; $display("FAIL midack_restart got acks=%b starts=%0d exp 00 1", {a0, a1}, n_start - s0); end
    n_vec++; if (rx_count - r0 !== 1 || rx_log[r0 % 64] !== 8'hC3) begin n_err++; $display("FAIL midack_byte got n=%0d d=%02h exp 1 C3", rx_count - r0, rx_log[r0 % 64]); end
    n_vec++; if (dir_bad !== 0) begin n_err++; $display("FAIL driver_rule got %0d bad cycles exp 0", dir_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_match();
    test_overrun();
    test_repeated_start();
    test_glitch();
    test_reset_mid_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
